// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames and
// strips E0/F0 prefixes, reporting make codes with an extended-key flag.
module ps2_scancode_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key,
    output logic       e0_flag,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

    logic          clk_s1_q, clk_s2_q, clk_h_q;
    logic          dat_s1_q, dat_s2_q;
    logic          fall;

    state_e        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          pend_e0_q, pend_e0_d;
    logic          pend_f0_q, pend_f0_d;
    logic [7:0]    key_q, key_d;
    logic          e0_q, e0_d;
    logic          kv_q, kv_d;
    logic          err_q, err_d;
    logic          byte_ok;

    // Synchronizers idle high so leaving reset never looks like a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_h_q  <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk;
            clk_s2_q <= clk_s1_q;
            clk_h_q  <= clk_s2_q;
            dat_s1_q <= ps2_data;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign fall = clk_h_q & ~clk_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            to_cnt_q  <= '0;
            pend_e0_q <= 1'b0;
            pend_f0_q <= 1'b0;
            key_q     <= '0;
            e0_q      <= 1'b0;
            kv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            to_cnt_q  <= to_cnt_d;
            pend_e0_q <= pend_e0_d;
            pend_f0_q <= pend_f0_d;
            key_q     <= key_d;
            e0_q      <= e0_d;
            kv_q      <= kv_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        pend_e0_d = pend_e0_q;
        pend_f0_d = pend_f0_q;
        key_d     = key_q;
        e0_d      = e0_q;
        kv_d      = 1'b0;
        err_d     = 1'b0;
        byte_ok   = 1'b0;

        if (state_q == S_IDLE || fall) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end

        if (state_q != S_IDLE && to_cnt_q == TO_MAX) begin
            state_d   = S_IDLE;
            to_cnt_d  = '0;
            err_d     = 1'b1;
            pend_e0_d = 1'b0;
            pend_f0_d = 1'b0;
        end else if (fall) begin
            case (state_q)
                S_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d   = {dat_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = S_PARITY;
                end
                S_PARITY: begin
                    par_d   = dat_s2_q;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (dat_s2_q && (^{shift_q, par_q})) begin
                        byte_ok = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        pend_e0_d = 1'b0;
                        pend_f0_d = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (byte_ok) begin
            case (shift_q)
                8'hE0: pend_e0_d = 1'b1;
                8'hF0: pend_f0_d = 1'b1;
                default: begin
                    if (!pend_f0_q) begin
                        key_d = shift_q;
                        e0_d  = pend_e0_q;
                        kv_d  = 1'b1;
                    end
                    pend_e0_d = 1'b0;
                    pend_f0_d = 1'b0;
                end
            endcase
        end
    end

    assign key       = key_q;
    assign e0_flag   = e0_q;
    assign key_valid = kv_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Self-checking bench for ps2_scancode_rx: fixed vector table, timeout and reset
// corner sequences, then random frames against a prefix-decoding reference model.
module tb_ps2_scancode_rx;

    localparam int unsigned TO = 100;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key;
    logic       e0_flag, key_valid, frame_err;

    ps2_scancode_rx #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .e0_flag(e0_flag), .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         kv_cyc[$];
    logic [7:0] kv_key[$];
    logic       kv_e0[$];
    int         err_cyc[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (key_valid) begin
                kv_cyc.push_back(cyc);
                kv_key.push_back(key);
                kv_e0.push_back(e0_flag);
            end
            if (frame_err) err_cyc.push_back(cyc);
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_q();
        kv_cyc.delete(); kv_key.delete(); kv_e0.delete(); err_cyc.delete();
    endtask

    int last_fall;

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = b[i];
            tick(H);
            ps2_clk = 1'b0;
            last_fall = cyc;
            tick(H);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] d, input bit badp, input bit stopv);
        return {stopv, (~^d) ^ badp, d, 1'b0};
    endfunction

    logic [7:0] cur_key = 8'h00;
    logic       cur_e0 = 1'b0;

    task automatic run_frame(input string nm, input logic [7:0] d, input bit badp, input bit stopv,
                             input bit ev, input logic [7:0] ek, input bit ee, input bit er);
        clear_q();
        send_bits(mkframe(d, badp, stopv), 11);
        tick(12);
        chk({nm, ".kv_count"}, kv_cyc.size(), int'(ev));
        chk({nm, ".err_count"}, err_cyc.size(), int'(er));
        if (ev && kv_cyc.size() == 1) begin
            chk({nm, ".kv_latency"}, kv_cyc[0] - last_fall, 3);
            chk({nm, ".key"}, int'(kv_key[0]), int'(ek));
            chk({nm, ".e0"}, int'(kv_e0[0]), int'(ee));
        end
        if (er && err_cyc.size() == 1) chk({nm, ".err_latency"}, err_cyc[0] - last_fall, 3);
        if (ev) begin
            cur_key = ek;
            cur_e0  = ee;
        end
        chk({nm, ".key_hold"}, int'(key), int'(cur_key));
        chk({nm, ".e0_hold"}, int'(e0_flag), int'(cur_e0));
    endtask

    // Reference model: prefix flags as plain booleans, decided per whole byte.
    bit m_e0 = 1'b0;
    bit m_f0 = 1'b0;

    task automatic model_step(input logic [7:0] d, input bit badp, input bit stopv,
                              output bit ev, output logic [7:0] ek, output bit ee, output bit er);
        ev = 1'b0; ek = 8'h00; ee = 1'b0; er = 1'b0;
        if (badp || !stopv) begin
            er = 1'b1; m_e0 = 1'b0; m_f0 = 1'b0;
        end else if (d == 8'hE0) begin
            m_e0 = 1'b1;
        end else if (d == 8'hF0) begin
            m_f0 = 1'b1;
        end else begin
            if (!m_f0) begin
                ev = 1'b1; ek = d; ee = m_e0;
            end
            m_e0 = 1'b0; m_f0 = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] d;
        bit         badp;
        bit         stopv;
        bit         ev;
        logic [7:0] ek;
        bit         ee;
        bit         er;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         ev, ee, er;
        logic [7:0] ek, d;
        bit         badp, stopv;
        int         dl;

        tbl.push_back('{8'h1C, 0, 1, 1, 8'h1C, 0, 0});
        tbl.push_back('{8'hE0, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h75, 0, 1, 1, 8'h75, 1, 0});
        tbl.push_back('{8'hF0, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h1C, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'hE0, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'hF0, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h75, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h29, 0, 1, 1, 8'h29, 0, 0});
        tbl.push_back('{8'h1C, 1, 1, 0, 8'h00, 0, 1});
        tbl.push_back('{8'h16, 0, 1, 1, 8'h16, 0, 0});
        tbl.push_back('{8'hE0, 0, 1, 0, 8'h00, 0, 0});
        tbl.push_back('{8'h33, 0, 0, 0, 8'h00, 0, 1});
        tbl.push_back('{8'h75, 0, 1, 1, 8'h75, 0, 0});
        tbl.push_back('{8'hE1, 0, 1, 1, 8'hE1, 0, 0});
        tbl.push_back('{8'hAA, 0, 1, 1, 8'hAA, 0, 0});
        tbl.push_back('{8'hFA, 0, 1, 1, 8'hFA, 0, 0});

        tick(3);
        chk("reset.key", int'(key), 0);
        chk("reset.e0", int'(e0_flag), 0);
        chk("reset.kv", int'(key_valid), 0);
        chk("reset.err", int'(frame_err), 0);
        rst = 1'b0;
        tick(5);

        for (int i = 0; i < tbl.size(); i++)
            run_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].badp, tbl[i].stopv,
                      tbl[i].ev, tbl[i].ek, tbl[i].ee, tbl[i].er);

        // Timeout mid-frame must also discard a pending E0.
        run_frame("to.e0", 8'hE0, 0, 1, 0, 8'h00, 0, 0);
        clear_q();
        send_bits(mkframe(8'h3C, 0, 1), 5);
        ps2_data = 1'b1;
        tick(TO + 10);
        chk("to.err_count", err_cyc.size(), 1);
        chk("to.kv_count", kv_cyc.size(), 0);
        if (err_cyc.size() == 1) begin
            dl = err_cyc[0] - last_fall;
            chk("to.err_window", int'(dl >= int'(TO) && dl <= int'(TO) + 6), 1);
        end
        run_frame("to.45", 8'h45, 0, 1, 1, 8'h45, 0, 0);

        // Reset mid-frame with a pending E0.
        run_frame("rst.e0", 8'hE0, 0, 1, 0, 8'h00, 0, 0);
        clear_q();
        send_bits(mkframe(8'h11, 0, 1), 5);
        ps2_data = 1'b1;
        rst = 1'b1;
        tick(2);
        chk("rst.key", int'(key), 0);
        chk("rst.e0", int'(e0_flag), 0);
        chk("rst.kv", int'(key_valid), 0);
        chk("rst.err", int'(frame_err), 0);
        rst = 1'b0;
        tick(TO + 20);
        chk("rst.err_after", err_cyc.size(), 0);
        chk("rst.kv_after", kv_cyc.size(), 0);
        cur_key = 8'h00;
        cur_e0  = 1'b0;
        run_frame("rst.5A", 8'h5A, 0, 1, 1, 8'h5A, 0, 0);

        m_e0 = 1'b0;
        m_f0 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    d = 8'hE0;
                2, 3:    d = 8'hF0;
                default: d = 8'($urandom);
            endcase
            badp  = ($urandom_range(0, 9) == 0);
            stopv = ($urandom_range(0, 14) != 0);
            model_step(d, badp, stopv, ev, ek, ee, er);
            run_frame($sformatf("rnd%0d", i), d, badp, stopv, ev, ek, ee, er);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_rx.md
PS2_SCANCODE_RX -- requirements
Module: ps2_scancode_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a PS/2 falling edge before a partial frame is abandoned.
REQ-002 SHALL have port clk  input  1  system clock; single clock domain; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-005 SHALL have port ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-006 SHALL have port key  output  8  last accepted make scan code, without prefix bytes.
REQ-007 SHALL have port e0_flag  output  1  1 when key was preceded by an E0 prefix.
REQ-008 SHALL have port key_valid  output  1  one-cycle pulse; key and e0_flag are new.
REQ-009 SHALL have port frame_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronizers, plus one history flop on ps2_clk.
REQ-011 SHALL detect a falling edge when the synchronized ps2_clk goes from 1 to 0 (history 1, current 0).
REQ-012 SHALL use frame FSM states IDLE, DATA, PARITY and STOP, acting only on the cycle a falling edge is detected.
REQ-013 IDLE SHALL go to DATA, with bit count 0, on an edge with synchronized data 0; on data 1 it SHALL stay in IDLE with no error.
REQ-014 DATA SHALL shift in 8 bits LSB first, then go to PARITY after the 8th bit.
REQ-015 PARITY SHALL capture the parity bit and go to STOP; the frame is valid only with odd parity over 8 data bits plus the parity bit.
REQ-016 STOP SHALL require data 1; the FSM then returns to IDLE.
REQ-017 A valid frame SHALL be handed to the prefix decoder in the same cycle the stop edge is detected.
REQ-018 An invalid frame SHALL pulse frame_err in the cycle after the stop edge, drop the byte and clear both prefix flags.
REQ-019 While the FSM is not in IDLE, the timeout counter SHALL count cycles and clear on each falling edge.
REQ-020 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL go to IDLE, pulse frame_err and clear both prefix flags.
REQ-021 The decoder SHALL hold flags pend_e0 and pend_f0.
REQ-022 Decoding rules:
  - Byte E0: SHALL set pend_e0.
  - Byte F0: SHALL set pend_f0.
  - Any other byte with pend_f0=1: SHALL be discarded (break code), and both flags SHALL be cleared.
  - Any other byte with pend_f0=0: SHALL load key<=byte and e0_flag<=pend_e0, pulse key_valid and clear both flags.
REQ-023 key_valid SHALL assert exactly 1 cycle after the cycle in which the stop-bit edge is detected, and SHALL last exactly 1 cycle.
REQ-024 key and e0_flag SHALL hold their values between key_valid pulses.
REQ-025 All bytes other than E0 and F0, including E1, AA and FA, SHALL be treated as ordinary key codes.
REQ-026 Each byte SHALL be decoded in a single cycle; there is no byte buffer.
REQ-027 Bytes arrive at least about 1 ms apart, so overrun is impossible and needs no handling.
REQ-028 The timeout counter SHALL be ceil(log2(TIMEOUT_CYCLES+1)) bits wide and SHALL saturate, never wrap.

Reset
REQ-029 rst SHALL asynchronously set:
  - FSM to IDLE;
  - bit count, shift register, timeout counter, pend_e0 and pend_f0 to 0;
  - key to 8'h00, e0_flag, key_valid and frame_err to 0;
  - all synchronizer and history flops to 1 (idle line), so releasing reset creates no false edge.
REQ-030 rst asserted mid-frame SHALL abandon the frame with no key_valid and no frame_err pulse.
REQ-031 The first falling edge after rst deasserts SHALL be treated as a possible start bit.

Verification
REQ-032 Frame 0x1C with parity 0 and stop 1 -> one key_valid pulse with key=8'h1C, e0_flag=0, 1 cycle after the stop edge.
REQ-033 Bytes E0 then 75 -> one key_valid pulse with key=8'h75, e0_flag=1; no pulse after the E0 byte.
REQ-034 Bytes F0 then 1C, then E0 F0 75, then 29 -> no key_valid during the break sequences; then one pulse with key=8'h29, e0_flag=0.
REQ-035 Byte 0x1C sent with parity 1 -> frame_err pulses once, no key_valid, key keeps its previous value; next good frame 0x16 gives key=8'h16.
REQ-036 Start bit plus 4 data bits, then a pause of TIMEOUT_CYCLES+10 cycles, then a full frame 0x45 -> frame_err pulses once at the timeout; then key=8'h45 with one key_valid pulse.
REQ-037 rst pulsed after 5 bits of a frame, then frame 0x5A -> all outputs 0 during reset, no frame_err; then key=8'h5A, e0_flag=0 with one key_valid pulse.
